// File: rtl/agc_pkg.sv
// Shared AGC definitions: word geometry, ALU operation codes and datapath mux encodings.
// The control FSM imports this package too, so the encodings stay identical on both sides.
package agc_pkg;

    localparam int AGC_WIDTH    = 15;
    localparam int AGC_ADDR_W   = 12;
    localparam int AGC_RESET_PC = 'h800;

    typedef enum logic [2:0] {
        ALU_AD   = 3'd0,
        ALU_SU   = 3'd1,
        ALU_MASK = 3'd2,
        ALU_MP0  = 3'd3,
        ALU_MP1  = 3'd4,
        ALU_DV0  = 3'd5,
        ALU_DV1  = 3'd6
    } alu_op_e;

    typedef enum logic { MADDR_Z  = 1'b0, MADDR_B = 1'b1 } maddr_sel_e;
    typedef enum logic { MDATA_A  = 1'b0, MDATA_L = 1'b1 } mdata_sel_e;
    typedef enum logic { LP_RDATA = 1'b0, LP_ALU  = 1'b1 } lp_sel_e;
    typedef enum logic { G_RDATA  = 1'b0, G_A     = 1'b1 } g_sel_e;
    typedef enum logic { B_RDATA  = 1'b0, B_ALU   = 1'b1 } b_sel_e;

    typedef enum logic [1:0] { Q_RDATA = 2'd0, Q_A = 2'd1, Q_Z = 2'd2, Q_ALU = 2'd3 } q_sel_e;
    typedef enum logic [1:0] { A_RDATA = 2'd0, A_ALU = 2'd1, A_NOT_G = 2'd2, A_G = 2'd3 } a_sel_e;
    typedef enum logic [1:0] { X_A = 2'd0, X_Z = 2'd1, X_B = 2'd2, X_DABS = 2'd3 } x_sel_e;
    typedef enum logic [1:0] { Z_RDATA = 2'd0, Z_ALU = 2'd1, Z_B = 2'd2, Z_Q = 2'd3 } z_sel_e;

    typedef enum logic [2:0] {
        Y_ZERO = 3'd0,
        Y_B    = 3'd1,
        Y_ONE  = 3'd2,
        Y_CCS  = 3'd3,
        Y_Q    = 3'd4
    } y_sel_e;

endpackage

// File: rtl/agc_alu.sv
// Combinational ones-complement ALU: add/subtract with end-around carry, mask,
// sign-magnitude multiply halves and divide quotient/remainder.
module agc_alu
    import agc_pkg::*;
#(
    parameter int WIDTH = AGC_WIDTH
)(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] result
);

    localparam int MW = WIDTH - 1;
    localparam int PW = 2 * MW;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [MW-1:0]    w_mx;
    logic [MW-1:0]    w_my;
    logic [PW-1:0]    w_prod;
    logic [MW-1:0]    w_quo;
    logic [MW-1:0]    w_rem;
    logic             w_sx;
    logic             w_sy;
    logic             w_s;

    assign w_sx = x[MW];
    assign w_sy = y[MW];
    assign w_s  = w_sx ^ w_sy;

    assign w_mx = w_sx ? ~x[MW-1:0] : x[MW-1:0];
    assign w_my = w_sy ? ~y[MW-1:0] : y[MW-1:0];

    assign w_sum  = {1'b0, x} + {1'b0, y};
    assign w_diff = {1'b0, x} + {1'b0, ~y};

    assign w_prod = PW'(w_mx) * PW'(w_my);

    // A quotient of two MW-bit magnitudes always fits in MW bits, so saturation
    // to max magnitude only happens for a zero divisor (either +0 or -0).
    assign w_quo = (w_my == '0) ? '1 : (w_mx / w_my);
    assign w_rem = (w_my == '0) ? '0 : (w_mx % w_my);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AD:   result = w_sum[WIDTH-1:0] + WIDTH'(w_sum[WIDTH]);
            ALU_SU:   result = w_diff[WIDTH-1:0] + WIDTH'(w_diff[WIDTH]);
            ALU_MASK: result = x & y;
            ALU_MP0:  result = {w_s, w_prod[MW-1:0] ^ {MW{w_s}}};
            ALU_MP1:  result = {w_s, w_prod[PW-1:MW] ^ {MW{w_s}}};
            ALU_DV0:  result = (w_my == '0) ? x : {w_sx, w_rem ^ {MW{w_sx}}};
            ALU_DV1:  result = {w_s, w_quo ^ {MW{w_s}}};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/agc_datapath.sv
// AGC register bank and source muxes driven by per-clock pulses from the control FSM;
// also drives the word memory interface and returns instruction-decode fields.
module agc_datapath
    import agc_pkg::*;
#(
    parameter int          WIDTH    = AGC_WIDTH,
    parameter int          ADDR_W   = AGC_ADDR_W,
    parameter int unsigned RESET_PC = AGC_RESET_PC
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_wr,
    input  logic              lp_wr,
    input  logic              g_wr,
    input  logic              q_wr,
    input  logic              b_wr,
    input  logic              a_wr,
    input  logic              y_wr,
    input  logic              x_wr,
    input  logic              z_wr,
    input  logic              maddr_mux,
    input  logic              mdata_mux,
    input  logic              lp_mux,
    input  logic              g_mux,
    input  logic              b_mux,
    input  logic [1:0]        q_mux,
    input  logic [1:0]        a_mux,
    input  logic [1:0]        x_mux,
    input  logic [1:0]        z_mux,
    input  logic [2:0]        alu_op,
    input  logic [2:0]        y_mux,
    input  logic              ext_flag,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    output logic [2:0]        opcode,
    output logic [1:0]        qc,
    output logic              extracode
);

    localparam int MW = WIDTH - 1;

    logic [WIDTH-1:0]  r_a, r_b, r_g, r_l, r_q, r_x, r_y;
    logic [ADDR_W-1:0] r_z;

    logic [WIDTH-1:0]  w_alu;
    logic [WIDTH-1:0]  w_z_ext;
    logic [MW-1:0]     w_g_mag;
    logic [WIDTH-1:0]  w_dabs;
    logic [WIDTH-1:0]  w_ccs;
    logic [WIDTH-1:0]  w_a_d, w_b_d, w_g_d, w_l_d, w_q_d, w_x_d, w_y_d;
    logic [ADDR_W-1:0] w_z_d;

    agc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x      (r_x),
        .y      (r_y),
        .alu_op (alu_op),
        .result (w_alu)
    );

    assign w_z_ext = WIDTH'(r_z);
    assign w_g_mag = r_g[MW] ? ~r_g[MW-1:0] : r_g[MW-1:0];
    assign w_dabs  = (w_g_mag != '0) ? {1'b0, w_g_mag - MW'(1)} : '0;

    // CCS branch offset: +nonzero 0, +0 1, -nonzero 2, -0 3.
    always_comb begin
        w_ccs = '0;
        if (r_a == '0) begin
            w_ccs = WIDTH'(1);
        end else if (r_a == '1) begin
            w_ccs = WIDTH'(3);
        end else if (r_a[MW]) begin
            w_ccs = WIDTH'(2);
        end
    end

    always_comb begin
        w_b_d = (b_mux  == B_ALU)  ? w_alu : mem_rdata;
        w_g_d = (g_mux  == G_A)    ? r_a   : mem_rdata;
        w_l_d = (lp_mux == LP_ALU) ? w_alu : mem_rdata;

        case (q_mux)
            Q_RDATA: w_q_d = mem_rdata;
            Q_A:     w_q_d = r_a;
            Q_Z:     w_q_d = w_z_ext;
            default: w_q_d = w_alu;
        endcase

        case (a_mux)
            A_RDATA: w_a_d = mem_rdata;
            A_ALU:   w_a_d = w_alu;
            A_NOT_G: w_a_d = ~r_g;
            default: w_a_d = r_g;
        endcase

        case (x_mux)
            X_A:     w_x_d = r_a;
            X_Z:     w_x_d = w_z_ext;
            X_B:     w_x_d = r_b;
            default: w_x_d = w_dabs;
        endcase

        case (y_mux)
            Y_B:     w_y_d = r_b;
            Y_ONE:   w_y_d = WIDTH'(1);
            Y_CCS:   w_y_d = w_ccs;
            Y_Q:     w_y_d = r_q;
            default: w_y_d = '0;
        endcase

        case (z_mux)
            Z_RDATA: w_z_d = mem_rdata[ADDR_W-1:0];
            Z_ALU:   w_z_d = w_alu[ADDR_W-1:0];
            Z_B:     w_z_d = r_b[ADDR_W-1:0];
            default: w_z_d = r_q[ADDR_W-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_g <= '0;
            r_l <= '0;
            r_q <= '0;
            r_x <= '0;
            r_y <= '0;
            r_z <= ADDR_W'(RESET_PC);
        end else begin
            if (a_wr)  r_a <= w_a_d;
            if (b_wr)  r_b <= w_b_d;
            if (g_wr)  r_g <= w_g_d;
            if (lp_wr) r_l <= w_l_d;
            if (q_wr)  r_q <= w_q_d;
            if (x_wr)  r_x <= w_x_d;
            if (y_wr)  r_y <= w_y_d;
            if (z_wr)  r_z <= w_z_d;
        end
    end

    // The write strobe is gated by reset so memory is never written while held in reset.
    assign mem_we    = mem_wr & rst_n;
    assign mem_addr  = (maddr_mux == MADDR_B) ? r_b[ADDR_W-1:0] : r_z;
    assign mem_wdata = (mdata_mux == MDATA_L) ? r_l : r_a;
    assign opcode    = mem_rdata[WIDTH-1 -: 3];
    assign qc        = mem_rdata[WIDTH-4 -: 2];
    assign extracode = ext_flag;

endmodule

// File: tb/tb_agc_datapath.sv
// Directed and randomized checks of agc_datapath against an integer-arithmetic
// ones-complement reference model.
module tb_agc_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr;
    logic        maddr_mux, mdata_mux, lp_mux, g_mux, b_mux;
    logic [1:0]  q_mux, a_mux, x_mux, z_mux;
    logic [2:0]  alu_op, y_mux;
    logic        ext_flag;
    logic [14:0] mem_rdata;
    logic [11:0] mem_addr;
    logic [14:0] mem_wdata;
    logic        mem_we;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic        extracode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    agc_datapath dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_wr    (mem_wr),
        .lp_wr     (lp_wr),
        .g_wr      (g_wr),
        .q_wr      (q_wr),
        .b_wr      (b_wr),
        .a_wr      (a_wr),
        .y_wr      (y_wr),
        .x_wr      (x_wr),
        .z_wr      (z_wr),
        .maddr_mux (maddr_mux),
        .mdata_mux (mdata_mux),
        .lp_mux    (lp_mux),
        .g_mux     (g_mux),
        .b_mux     (b_mux),
        .q_mux     (q_mux),
        .a_mux     (a_mux),
        .x_mux     (x_mux),
        .z_mux     (z_mux),
        .alu_op    (alu_op),
        .y_mux     (y_mux),
        .ext_flag  (ext_flag),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .opcode    (opcode),
        .qc        (qc),
        .extracode (extracode)
    );

    // Reference model: words treated as ones-complement numbers using plain integers.
    function automatic int mag(input logic [14:0] v);
        return v[14] ? (32'h7FFF - int'(v)) : int'(v);
    endfunction

    function automatic logic [14:0] enc(input logic neg, input int m);
        return neg ? 15'(32'h7FFF - m) : 15'(m);
    endfunction

    function automatic logic [14:0] ocAdd(input int a, input int b);
        int s;
        s = a + b;
        if (s > 32'h7FFF) s = s - 32'h7FFF;
        return 15'(s);
    endfunction

    function automatic logic [14:0] modelAlu(input logic [14:0] x, input logic [14:0] y, input logic [2:0] op);
        int   mx, my, p, q;
        logic sp;
        mx = mag(x);
        my = mag(y);
        sp = x[14] ^ y[14];
        p  = mx * my;
        case (op)
            3'd0: return ocAdd(int'(x), int'(y));
            3'd1: return ocAdd(int'(x), 32'h7FFF - int'(y));
            3'd2: return x & y;
            3'd3: return enc(sp, p % 16384);
            3'd4: return enc(sp, p / 16384);
            3'd5: begin
                if (my == 0) return x;
                return enc(x[14], mx % my);
            end
            3'd6: begin
                if (my == 0) q = 16383;
                else q = mx / my;
                if (q > 16383) q = 16383;
                return enc(sp, q);
            end
            default: return 15'h0;
        endcase
    endfunction

    function automatic logic [14:0] pickWord();
        int r;
        r = int'($urandom_range(7, 0));
        case (r)
            0: return 15'h0000;
            1: return 15'h7FFF;
            2: return 15'h3FFF;
            3: return 15'h4000;
            default: return 15'($urandom);
        endcase
    endfunction

    task automatic idle();
        {mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr} = '0;
        {maddr_mux, mdata_mux, lp_mux, g_mux, b_mux} = '0;
        q_mux = '0; a_mux = '0; x_mux = '0; z_mux = '0;
        alu_op = '0; y_mux = '0; ext_flag = 1'b0; mem_rdata = '0;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic peekA(output logic [14:0] v);
        mdata_mux = 1'b0; #1; v = mem_wdata;
    endtask

    task automatic peekL(output logic [14:0] v);
        mdata_mux = 1'b1; #1; v = mem_wdata;
    endtask

    task automatic peekZ(output logic [11:0] v);
        maddr_mux = 1'b0; #1; v = mem_addr;
    endtask

    task automatic loadXY(input logic [14:0] xv, input logic [14:0] yv);
        idle();
        mem_rdata = xv; a_wr = 1'b1;
        applyStimulus();
        mem_rdata = yv; b_wr = 1'b1; x_wr = 1'b1; x_mux = 2'd0;
        applyStimulus();
        y_wr = 1'b1; y_mux = 3'd1;
        applyStimulus();
    endtask

    task automatic runAlu(input logic [14:0] xv, input logic [14:0] yv, input logic [2:0] op, output logic [14:0] res);
        loadXY(xv, yv);
        alu_op = op; a_wr = 1'b1; a_mux = 2'd1;
        applyStimulus();
        peekA(res);
    endtask

    task automatic ccsCheck(input string tag, input logic [14:0] av, input int expv);
        logic [14:0] v;
        idle();
        mem_rdata = 15'h0; g_wr = 1'b1;
        applyStimulus();
        mem_rdata = av; a_wr = 1'b1;
        applyStimulus();
        y_wr = 1'b1; y_mux = 3'd3; x_wr = 1'b1; x_mux = 2'd3;
        applyStimulus();
        alu_op = 3'd0; a_wr = 1'b1; a_mux = 2'd1;
        applyStimulus();
        peekA(v);
        checkOutput(tag, 32'(v), 32'(expv));
    endtask

    initial begin
        logic [14:0] v, res, xv, yv;
        logic [11:0] zv;
        logic [2:0]  op;

        $display("[TB] start");
        idle();
        rst_n = 1'b0;
        a_wr = 1'b1; mem_wr = 1'b1; mem_rdata = 15'h1234;
        repeat (3) @(posedge clk);
        #1;
        mdata_mux = 1'b0; maddr_mux = 1'b0; #1;
        checkOutput("reset_A", 32'(mem_wdata), 32'h0);
        checkOutput("reset_Z", 32'(mem_addr), 32'h800);
        checkOutput("reset_we", 32'(mem_we), 32'h0);
        idle();
        rst_n = 1'b1;
        #1;

        runAlu(15'h7FFE, 15'h0001, 3'd0, res);
        checkOutput("ad_neg_zero", 32'(res), 32'h7FFF);
        runAlu(15'h7FFE, 15'h0002, 3'd0, res);
        checkOutput("ad_end_carry", 32'(res), 32'h0001);
        runAlu(15'h0005, 15'h0003, 3'd1, res);
        checkOutput("su_basic", 32'(res), 32'h0002);

        loadXY(15'h0003, 15'h7FFB);
        alu_op = 3'd3; lp_wr = 1'b1; lp_mux = 1'b1;
        applyStimulus();
        alu_op = 3'd4; a_wr = 1'b1; a_mux = 2'd1;
        applyStimulus();
        peekL(v);
        checkOutput("mp0_L", 32'(v), 32'h7FF3);
        peekA(v);
        checkOutput("mp1_A", 32'(v), 32'h7FFF);

        runAlu(15'h0007, 15'h0000, 3'd6, res);
        checkOutput("dv1_div0", 32'(res), 32'h3FFF);
        runAlu(15'h0007, 15'h0000, 3'd5, res);
        checkOutput("dv0_div0", 32'(res), 32'h0007);
        runAlu(15'h0007, 15'h7FFF, 3'd6, res);
        checkOutput("dv1_divm0", 32'(res), 32'h4000);
        runAlu(15'h0007, 15'h0002, 3'd6, res);
        checkOutput("dv1_7_2", 32'(res), 32'h0003);
        runAlu(15'h0007, 15'h0002, 3'd5, res);
        checkOutput("dv0_7_2", 32'(res), 32'h0001);

        ccsCheck("ccs_pzero", 15'h0000, 1);
        ccsCheck("ccs_mzero", 15'h7FFF, 3);
        ccsCheck("ccs_pos", 15'h0005, 0);
        ccsCheck("ccs_neg", 15'h7FFA, 2);

        idle();
        mem_rdata = 15'h7FFA; g_wr = 1'b1;
        applyStimulus();
        x_wr = 1'b1; x_mux = 2'd3; y_wr = 1'b1; y_mux = 3'd0;
        applyStimulus();
        alu_op = 3'd0; a_wr = 1'b1; a_mux = 2'd1;
        applyStimulus();
        peekA(v);
        checkOutput("dabs_m5", 32'(v), 32'h0004);
        a_wr = 1'b1; a_mux = 2'd2;
        applyStimulus();
        peekA(v);
        checkOutput("a_not_g", 32'(v), 32'h0005);
        mem_rdata = 15'h0001; g_wr = 1'b1;
        applyStimulus();
        x_wr = 1'b1; x_mux = 2'd3;
        applyStimulus();
        alu_op = 3'd0; a_wr = 1'b1; a_mux = 2'd1;
        applyStimulus();
        peekA(v);
        checkOutput("dabs_p1", 32'(v), 32'h0000);

        idle();
        mem_rdata = 15'h5400; ext_flag = 1'b1; #1;
        checkOutput("opcode", 32'(opcode), 32'd5);
        checkOutput("qc", 32'(qc), 32'd1);
        checkOutput("extracode_1", 32'(extracode), 32'd1);
        ext_flag = 1'b0; #1;
        checkOutput("extracode_0", 32'(extracode), 32'd0);

        idle();
        mem_rdata = 15'h0123; b_wr = 1'b1;
        applyStimulus();
        mem_rdata = 15'h2A5C; a_wr = 1'b1;
        applyStimulus();
        mem_wr = 1'b1; mdata_mux = 1'b0; maddr_mux = 1'b1; #1;
        checkOutput("memwr_addr", 32'(mem_addr), 32'h123);
        checkOutput("memwr_data", 32'(mem_wdata), 32'h2A5C);
        checkOutput("memwr_we", 32'(mem_we), 32'd1);
        mdata_mux = 1'b1; #1;
        checkOutput("memwr_dataL", 32'(mem_wdata), 32'h7FF3);

        idle();
        mem_rdata = 15'h0FFF; z_wr = 1'b1; z_mux = 2'd0;
        applyStimulus();
        peekZ(zv);
        checkOutput("z_load", 32'(zv), 32'hFFF);
        x_wr = 1'b1; x_mux = 2'd1; y_wr = 1'b1; y_mux = 3'd2; q_wr = 1'b1; q_mux = 2'd2;
        applyStimulus();
        alu_op = 3'd0; z_wr = 1'b1; z_mux = 2'd1;
        applyStimulus();
        peekZ(zv);
        checkOutput("z_wrap", 32'(zv), 32'((32'hFFF + 1) % 4096));
        z_wr = 1'b1; z_mux = 2'd3;
        applyStimulus();
        peekZ(zv);
        checkOutput("z_from_q", 32'(zv), 32'hFFF);

        @(posedge clk);
        #2;
        rst_n = 1'b0; a_wr = 1'b1; mem_rdata = 15'h1111; #1;
        peekA(v);
        checkOutput("midrst_A", 32'(v), 32'h0);
        peekZ(zv);
        checkOutput("midrst_Z", 32'(zv), 32'h800);
        @(posedge clk);
        #1;
        peekA(v);
        checkOutput("midrst_hold", 32'(v), 32'h0);
        idle();
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 40; i++) begin
            xv = pickWord();
            yv = pickWord();
            op = 3'($urandom_range(6, 0));
            runAlu(xv, yv, op, res);
            checkOutput($sformatf("rand%0d_op%0d_x%0h_y%0h", i, op, xv, yv), 32'(res), 32'(modelAlu(xv, yv, op)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
